// File: rtl/ram_port_arbiter.sv
// Two-requester RAM port arbiter (instruction read port, data read/write port) with programmer blocking.
// Define ARB_ROUND_ROBIN_EN for alternating arbitration on contention; default is fixed data-over-instruction priority.
module ram_port_arbiter #(
    parameter int ADDR_W = 17,
    parameter int NB_COL = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                prog_busy_i,
    // instruction requester
    input  logic                ins_req_i,
    input  logic [ADDR_W-1:0]   ins_addr_i,
    output logic                ins_gnt_o,
    output logic                ins_rvalid_o,
    output logic [NB_COL*8-1:0] ins_rdata_o,
    // data requester
    input  logic                dat_req_i,
    input  logic                dat_we_i,
    input  logic [NB_COL-1:0]   dat_strb_i,
    input  logic [ADDR_W-1:0]   dat_addr_i,
    input  logic [NB_COL*8-1:0] dat_wdata_i,
    output logic                dat_gnt_o,
    output logic                dat_rvalid_o,
    output logic [NB_COL*8-1:0] dat_rdata_o,
    // RAM side
    output logic                ram_rd_en_o,
    output logic [ADDR_W-1:0]   ram_rd_addr_o,
    output logic [ADDR_W-1:0]   ram_wr_addr_o,
    output logic [NB_COL*8-1:0] ram_wr_data_o,
    output logic [NB_COL-1:0]   ram_wr_strb_o,
    input  logic [NB_COL*8-1:0] ram_rd_data_i,
    // debug: 0 = IDLE, 1 = SERVE, 2 = BLOCK
    output logic [1:0]          state_o
);

    // Handshake: a request is accepted in the cycle its gnt is high; requesters hold
    // address/data/strobe stable until then. rvalid is high for exactly one cycle,
    // one cycle after the grant, and the owner must accept it unconditionally.

    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, BLOCK = 2'd2} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_INS, OWN_DAT_RD, OWN_DAT_WR} owner_t;

    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    logic   can_grant;
    logic   pick_dat;

    assign can_grant = !rst_i && !prog_busy_i && (state_q != BLOCK);

`ifdef ARB_ROUND_ROBIN_EN
    // set when the data port won the most recent simultaneous-request grant
    logic last_dat_q;

    assign pick_dat = dat_req_i && (!ins_req_i || !last_dat_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_dat_q <= 1'b0;
        end else if (can_grant && ins_req_i && dat_req_i) begin
            last_dat_q <= pick_dat;
        end
    end
`else
    assign pick_dat = dat_req_i;
`endif

    assign dat_gnt_o = can_grant && pick_dat;
    assign ins_gnt_o = can_grant && ins_req_i && !pick_dat;

    assign ram_rd_en_o   = ins_gnt_o || (dat_gnt_o && !dat_we_i);
    assign ram_rd_addr_o = ins_gnt_o ? ins_addr_i : dat_addr_i;
    assign ram_wr_addr_o = dat_addr_i;
    assign ram_wr_data_o = dat_wdata_i;
    assign ram_wr_strb_o = (dat_gnt_o && dat_we_i) ? dat_strb_i : '0;

    always_comb begin
        state_d = IDLE;
        owner_d = OWN_NONE;
        if (ins_gnt_o) begin
            owner_d = OWN_INS;
        end else if (dat_gnt_o) begin
            owner_d = dat_we_i ? OWN_DAT_WR : OWN_DAT_RD;
        end
        if (prog_busy_i) begin
            state_d = BLOCK;
        end else if (state_q == BLOCK) begin
            state_d = IDLE;
        end else if (ins_gnt_o || dat_gnt_o) begin
            state_d = SERVE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Responses are gated by reset so an access in flight when reset arrives is dropped.
    assign ins_rvalid_o = !rst_i && (owner_q == OWN_INS);
    assign dat_rvalid_o = !rst_i && (owner_q == OWN_DAT_RD || owner_q == OWN_DAT_WR);
    assign ins_rdata_o  = ins_rvalid_o ? ram_rd_data_i : '0;
    assign dat_rdata_o  = (!rst_i && owner_q == OWN_DAT_RD) ? ram_rd_data_i : '0;

    assign state_o = state_q;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 17, the RAM word-address width.
REQ-002 SHALL take parameter NB_COL, default 4, the number of byte lanes; data width is NB_COL*8.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, the reset, which is synchronous and active-high.
REQ-005 SHALL have port prog_busy_i, input, 1; high while the UART programmer owns the RAM, and it blocks new grants.
REQ-006 SHALL have instruction-requester ports (read-only):
- ins_req_i, input, 1
- ins_addr_i, input, ADDR_W
- ins_gnt_o, output, 1
- ins_rvalid_o, output, 1
- ins_rdata_o, output, NB_COL*8
REQ-007 SHALL have data-requester ports:
- dat_req_i, input, 1
- dat_we_i, input, 1
- dat_strb_i, input, NB_COL
- dat_addr_i, input, ADDR_W
- dat_wdata_i, input, NB_COL*8
- dat_gnt_o, output, 1
- dat_rvalid_o, output, 1
- dat_rdata_o, output, NB_COL*8
REQ-008 SHALL have RAM-side ports:
- ram_rd_en_o, output, 1
- ram_rd_addr_o, output, ADDR_W
- ram_wr_addr_o, output, ADDR_W
- ram_wr_data_o, output, NB_COL*8
- ram_wr_strb_o, output, NB_COL
- ram_rd_data_i, input, NB_COL*8; registered, valid one cycle after ram_rd_en_o.

Function
REQ-009 SHALL grant at most one requester per cycle; the grant is combinational in the same cycle as the request.
REQ-010 SHALL keep a state machine with states IDLE, SERVE and BLOCK, defined as follows:
- IDLE: no grant last cycle.
- SERVE: a grant was issued last cycle.
- BLOCK: prog_busy_i was sampled high.
REQ-011 SHALL make the state transitions as follows:
- Any state goes to BLOCK when prog_busy_i=1.
- BLOCK goes to IDLE the cycle after prog_busy_i=0.
- IDLE or SERVE goes to SERVE if a grant is issued, else to IDLE.
REQ-012 SHALL issue no grant in BLOCK or while prog_busy_i=1, and SHALL drive ram_rd_en_o=0 and ram_wr_strb_o=0 then.
REQ-013 SHALL drive the RAM for a granted instruction request with ram_rd_en_o=1, ram_rd_addr_o=ins_addr_i and ram_wr_strb_o=0.
REQ-014 SHALL drive the RAM for a granted data read (dat_we_i=0) with ram_rd_en_o=1, ram_rd_addr_o=dat_addr_i and ram_wr_strb_o=0.
REQ-015 SHALL drive the RAM for a granted data write (dat_we_i=1) with ram_wr_addr_o=dat_addr_i, ram_wr_data_o=dat_wdata_i, ram_wr_strb_o=dat_strb_i and ram_rd_en_o=0.
REQ-016 SHALL register the owner of each grant (ins/dat) and the kind (read/write) for one cycle, and route ram_rd_data_i to that owner's rdata in the following cycle with rvalid=1 for exactly one cycle.
REQ-017 SHALL acknowledge a data write with dat_rvalid_o=1 one cycle after the grant, with dat_rdata_o undefined-but-stable (driven 0).
REQ-018 SHALL allow back-to-back grants every cycle (throughput 1 access/cycle, latency 1 cycle).
REQ-019 SHALL deliver a response whose grant preceded prog_busy_i rising, even though the state is BLOCK in the response cycle.
REQ-020 SHALL NOT let requesters change address, data or strobe between request and grant; the arbiter need not latch them.
REQ-021 SHALL ignore a data write with dat_strb_i=0 at the RAM, but still grant and acknowledge it.
REQ-022 SHALL keep a last-winner pointer; when both requesters request, the grant goes per the configuration (REQ-026/027), and the pointer updates only on a simultaneous-request grant.

Reset
REQ-023 SHALL, on rst_i=1 at a clock edge, set the state to IDLE, the owner register to none, the last-winner pointer to ins, and both rvalid outputs to 0.
REQ-024 SHALL hold both grant outputs, ram_rd_en_o and ram_wr_strb_o at 0 while rst_i=1; a response in flight at reset is discarded.
REQ-025 SHALL hold rdata outputs at 0 out of reset until the first response.

Configuration
REQ-026 SHALL, with macro ARB_ROUND_ROBIN_EN defined, grant simultaneous requests to the requester that did not win the last simultaneous grant, alternating between them.
REQ-027 SHALL, without ARB_ROUND_ROBIN_EN, use fixed priority with data over instruction; the pointer is then unused and its register is removed.

Verification
REQ-028 SHALL cover read latency: ins_req_i=1, ins_addr_i=0x10, RAM word 0x10=0xDEADBEEF -> ins_gnt_o=1 in cycle 0 and ins_rvalid_o=1 with ins_rdata_o=0xDEADBEEF in cycle 1.
REQ-029 SHALL cover a byte write: dat_we_i=1, dat_strb_i=4'b0011, addr 0x20, wdata 0x11223344 -> ram_wr_strb_o=4'b0011 in the grant cycle and dat_rvalid_o=1 next cycle; a later read returns the low half 0x3344 with the upper bytes unchanged.
REQ-030 SHALL cover contention: both requesting for 4 cycles -> with ARB_ROUND_ROBIN_EN the grants are dat, ins, dat, ins; without it the grants are dat x4 and ins_gnt_o=0.
REQ-031 SHALL cover programmer blocking: prog_busy_i=1 for 10 cycles while both request -> no grants and the RAM idle; the response from a grant one cycle before the block is still delivered; grants resume one cycle after prog_busy_i falls.
REQ-032 SHALL cover reset mid-access: a grant in cycle 0 with rst_i=1 in cycle 1 -> no rvalid in cycle 1 or 2, and the state is IDLE after reset.
REQ-033 SHALL cover back-to-back operation: an ins read at 0x0 then a dat read at 0x4 in consecutive cycles -> rvalid for each on the correct port, one cycle apart, with correct data.
